// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one aligned read at a time to instruction
// memory, holds the returned word for decode, and drops responses that a
// redirect has made stale. A misaligned PC parks the unit in a fault state.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_en,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  output logic              fetch_err,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   discard;
  logic   aligned;
  logic   launch;
  logic   accept;
  logic   xfer;

  assign aligned = (pc_addr[1:0] == 2'b00);

  // State register; reset abandons any outstanding request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: new fetches are alignment-checked both from IDLE and right after a transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_en && !redirect) begin
          state_nxt = aligned ? REQ : ERR;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_nxt = (discard || redirect) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = IDLE;
        end else if (inst_ready) begin
          if (!fetch_en) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = aligned ? REQ : ERR;
          end
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and per-cycle control decoded from the current state
  always_comb begin
    imem_req   = (state == REQ);
    inst_valid = (state == HOLD);
    fetch_err  = (state == ERR);
    launch     = (state_nxt == REQ) && (state != REQ);
    accept     = (state == REQ) && imem_ack && !discard && !redirect;
    xfer       = (state == HOLD) && inst_ready;
  end

  // Request address, captured instruction and the one-cycle advance pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      pc_advance <= 1'b0;
    end else begin
      pc_advance <= accept;
      if (launch) begin
        imem_addr <= pc_addr;
      end
      if (accept) begin
        inst    <= imem_rdata;
        inst_pc <= imem_addr;
      end
    end
  end

  // Discard flag marks the outstanding response as stale after a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= 1'b0;
    end else if (state == REQ) begin
      if (imem_ack) begin
        discard <= 1'b0;
      end else if (redirect) begin
        discard <= 1'b1;
      end
    end else begin
      discard <= 1'b0;
    end
  end

  // Delivered-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (xfer) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: instruction address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: instruction word width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port pc_addr, input, ADDR_W: current address from the PC register.
REQ-006 The block SHALL have port fetch_en, input, 1: permission to start a new fetch.
REQ-007 The block SHALL have port pc_advance, output, 1: single-cycle pulse telling next-PC logic to load the PC.
REQ-008 The block SHALL have port imem_req, output, 1: instruction memory read request.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W: request address.
REQ-010 The block SHALL have port imem_ack, input, 1: memory read-data-valid strobe, any latency of 1 cycle or more.
REQ-011 The block SHALL have port imem_rdata, input, DATA_W: read data, valid when imem_ack=1.
REQ-012 The block SHALL have port inst_valid, output, 1: instruction offered to decode.
REQ-013 The block SHALL have port inst_ready, input, 1: decode accepts.
REQ-014 The block SHALL have port inst, output, DATA_W: fetched instruction word.
REQ-015 The block SHALL have port inst_pc, output, ADDR_W: address of inst.
REQ-016 The block SHALL have port redirect, input, 1: branch or jump flush.
REQ-017 The block SHALL have port fetch_err, output, 1: sticky misaligned-address fault.
REQ-018 The block SHALL have port fetch_cnt, output, 16: count of delivered instructions.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, HOLD, ERR.
REQ-020 In IDLE with fetch_en=1 and redirect=0: if pc_addr[1:0]==0, the block SHALL latch imem_addr<=pc_addr, set imem_req=1 and enter REQ.
REQ-021 In IDLE with fetch_en=1 and redirect=0: if pc_addr[1:0]!=0, the block SHALL set fetch_err=1 and enter ERR; no request is issued.
REQ-022 In REQ, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-023 On imem_ack with no pending discard, the block SHALL register inst<=imem_rdata and inst_pc<=imem_addr, set inst_valid=1, drop imem_req, enter HOLD, and assert pc_advance for exactly that one cycle.
REQ-024 On redirect=1 while in REQ, the block SHALL set a discard flag.
REQ-025 On imem_ack with discard set, or with redirect=1 in the ack cycle, the block SHALL drop the data, assert no pc_advance and no inst_valid, clear discard, and return to IDLE.
REQ-026 In HOLD, inst_valid, inst and inst_pc SHALL remain stable until inst_valid and inst_ready are both 1.
REQ-027 A transfer (valid and ready in the same cycle) SHALL increment fetch_cnt by 1, wrapping from 0xFFFF to 0x0000.
REQ-028 After a transfer, the block SHALL clear inst_valid next cycle, go to REQ (fetching the pc_addr sampled in that cycle, with the alignment check of REQ-020/021) if fetch_en=1, else go to IDLE.
REQ-029 redirect=1 in HOLD SHALL clear inst_valid next cycle and return to IDLE; if inst_ready=1 in the same cycle the transfer still counts.
REQ-030 ERR SHALL be terminal until reset: no requests, inst_valid=0, fetch_err=1.
REQ-031 At most one memory request SHALL be outstanding at any time.
REQ-032 Back-to-back throughput SHALL be one instruction per (memory latency + 1) cycles when inst_ready is held high.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE; imem_req, inst_valid, pc_advance, fetch_err and discard to 0; imem_addr, inst, inst_pc and fetch_cnt to 0.
REQ-034 Reset during REQ SHALL abandon the outstanding request; an imem_ack arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-035 Basic fetch: pc_addr=0x100, fetch_en=1, ack after 2 cycles with rdata=0x8C010004 -> inst=0x8C010004, inst_pc=0x100, one pc_advance pulse, fetch_cnt=1 after the handshake.
REQ-036 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst, inst_pc and inst_valid stable, no new imem_req; ready=1 -> transfer, then request for the new pc_addr (0x104).
REQ-037 Redirect in REQ: redirect pulse one cycle after request, ack with 0xDEADBEEF -> no inst_valid, no pc_advance, FSM in IDLE, fetch_cnt unchanged.
REQ-038 Misalignment: pc_addr=0x102, fetch_en=1 -> fetch_err=1, imem_req never asserted, stays in ERR until rst_n=0.
REQ-039 Counter wrap: preload with 0xFFFF transfers, one more transfer -> fetch_cnt=0x0000.
REQ-040 Async reset mid-REQ: rst_n low between clock edges -> imem_req=0 without waiting for a clock edge; a late ack after release produces no inst_valid.
